// File: rtl/dram_cache_req_arbiter_if.sv
// Bundle of host request, DRAM AR, tag FIFO and credit-return signals around the
// DRAM cache request arbiter. The master modport is the arbiter's side; the slave
// modport is the surrounding environment (host, DRAM, tag comparator).
interface dram_cache_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                           rd_req_valid_i;
    logic                           rd_req_ready_o;
    logic [ADDR_WIDTH-1:0]          rd_req_addr_i;
    logic [ID_WIDTH-1:0]            rd_req_id_i;
    logic                           wr_req_valid_i;
    logic                           wr_req_ready_o;
    logic [ADDR_WIDTH-1:0]          wr_req_addr_i;
    logic [ID_WIDTH-1:0]            wr_req_id_i;
    logic [ID_WIDTH-1:0]            arid_o;
    logic [ADDR_WIDTH-1:0]          araddr_o;
    logic [7:0]                     arlen_o;
    logic [2:0]                     arsize_o;
    logic [1:0]                     arburst_o;
    logic                           arvalid_o;
    logic                           arready_i;
    logic                           tag_fifo_afull_i;
    logic                           tag_fifo_wren_o;
    logic [ADDR_WIDTH+ID_WIDTH:0]   tag_fifo_data_o;
    logic                           done_i;
    logic [3:0]                     outstanding_o;

    modport master (
        input  rd_req_valid_i, rd_req_addr_i, rd_req_id_i,
        input  wr_req_valid_i, wr_req_addr_i, wr_req_id_i,
        input  arready_i, tag_fifo_afull_i, done_i,
        output rd_req_ready_o, wr_req_ready_o,
        output arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
        output tag_fifo_wren_o, tag_fifo_data_o, outstanding_o
    );

    modport slave (
        output rd_req_valid_i, rd_req_addr_i, rd_req_id_i,
        output wr_req_valid_i, wr_req_addr_i, wr_req_id_i,
        output arready_i, tag_fifo_afull_i, done_i,
        input  rd_req_ready_o, wr_req_ready_o,
        input  arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
        input  tag_fifo_wren_o, tag_fifo_data_o, outstanding_o
    );
endinterface

// File: rtl/dram_cache_req_arbiter.sv
// Round-robin read/write arbiter feeding DRAM cache probes onto one AR channel,
// with a matching tag FIFO descriptor push and an in-flight credit limit.
//
// state   | meaning
// S_IDLE  | waiting for a request; grant evaluated here only
// S_ISSUE | AR held valid with latched probe until arready
module dram_cache_req_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int INDEX_WIDTH     = 10,
    parameter int OFFSET_WIDTH    = 6,
    parameter int BURST_LEN       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dram_cache_req_arbiter_if.master bus
);
    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    // Bytes per beat is the line size spread over the burst.
    localparam logic [2:0] AR_SIZE  = 3'($clog2((1 << OFFSET_WIDTH) / BURST_LEN));
    localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK = {{(ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH){1'b0}},
                                                  {INDEX_WIDTH{1'b1}}, {OFFSET_WIDTH{1'b0}}};

    state_t                  state;
    logic                    last_wr;
    logic                    lat_wr;
    logic [ID_WIDTH-1:0]     lat_id;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [ID_WIDTH-1:0]     arid_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    arvalid_q;
    logic [3:0]              outstanding;
    logic                    grant;
    logic                    grant_wr;
    logic                    handshake;

    // Grant decision; ready is gated by rst_n so nothing is accepted while in reset.
    always_comb begin
        grant    = rst_n && (state == S_IDLE)
                   && (bus.rd_req_valid_i || bus.wr_req_valid_i)
                   && !bus.tag_fifo_afull_i && (outstanding < MAX_CNT);
        grant_wr = bus.wr_req_valid_i && (!bus.rd_req_valid_i || !last_wr);
    end

    assign handshake           = arvalid_q && bus.arready_i;
    assign bus.rd_req_ready_o  = grant && !grant_wr;
    assign bus.wr_req_ready_o  = grant && grant_wr;
    assign bus.arid_o          = arid_q;
    assign bus.araddr_o        = araddr_q;
    assign bus.arlen_o         = 8'(BURST_LEN - 1);
    assign bus.arsize_o        = AR_SIZE;
    assign bus.arburst_o       = 2'b01;
    assign bus.arvalid_o       = arvalid_q;
    assign bus.tag_fifo_wren_o = handshake;
    assign bus.tag_fifo_data_o = {lat_wr, lat_id, lat_addr};
    assign bus.outstanding_o   = outstanding;

    // Request FSM: latch the granted request, then hold AR until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last_wr   <= 1'b1;
            lat_wr    <= 1'b0;
            lat_id    <= '0;
            lat_addr  <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        last_wr   <= grant_wr;
                        lat_wr    <= grant_wr;
                        lat_id    <= grant_wr ? bus.wr_req_id_i : bus.rd_req_id_i;
                        lat_addr  <= grant_wr ? bus.wr_req_addr_i : bus.rd_req_addr_i;
                        arid_q    <= grant_wr ? bus.wr_req_id_i : bus.rd_req_id_i;
                        araddr_q  <= (grant_wr ? bus.wr_req_addr_i : bus.rd_req_addr_i) & IDX_MASK;
                        arvalid_q <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (handshake) begin
                        arvalid_q <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Credit counter: +1 per AR handshake, -1 per completion, floored at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (handshake && !bus.done_i) begin
            outstanding <= outstanding + 4'd1;
        end else if (!handshake && bus.done_i && (outstanding != 4'd0)) begin
            outstanding <= outstanding - 4'd1;
        end
    end
endmodule

// File: tb/tb_dram_cache_req_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// transaction-level model of the arbiter.
module tb_dram_cache_req_arbiter;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int MAXO = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // model state
    bit              m_busy;
    bit              m_wr;
    logic [IW-1:0]   m_id;
    logic [AW-1:0]   m_addr;
    int              m_cnt;
    bit              m_last_wr;

    // samples captured at the last check point
    logic            s_rd_ready, s_wr_ready, s_wren;
    logic [AW-1:0]   s_araddr;
    logic [IW-1:0]   s_arid;
    logic [AW+IW:0]  s_data;
    logic [3:0]      s_outstanding;

    dram_cache_req_arbiter_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) ifc ();

    dram_cache_req_arbiter #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .INDEX_WIDTH(10), .OFFSET_WIDTH(6),
        .BURST_LEN(8), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_id = '0; m_addr = '0; m_cnt = 0; m_last_wr = 1;
    endtask

    // One clock cycle: drive at edge+1, compare at the falling edge, advance the model.
    task automatic step(input bit rv, input logic [AW-1:0] ra, input logic [IW-1:0] rid,
                        input bit wv, input logic [AW-1:0] wa, input logic [IW-1:0] wid,
                        input bit afull, input bit arready, input bit done);
        bit            ok, pick_wr, hs;
        logic [AW-1:0] exp_araddr;
        ifc.rd_req_valid_i   = rv;  ifc.rd_req_addr_i = ra;  ifc.rd_req_id_i = rid;
        ifc.wr_req_valid_i   = wv;  ifc.wr_req_addr_i = wa;  ifc.wr_req_id_i = wid;
        ifc.tag_fifo_afull_i = afull;
        ifc.arready_i        = arready;
        ifc.done_i           = done;
        #4;
        ok      = !m_busy && (rv || wv) && !afull && (m_cnt < MAXO);
        pick_wr = wv && (!rv || !m_last_wr);
        hs      = m_busy && arready;
        s_rd_ready = ifc.rd_req_ready_o; s_wr_ready = ifc.wr_req_ready_o;
        s_wren = ifc.tag_fifo_wren_o; s_araddr = ifc.araddr_o; s_arid = ifc.arid_o;
        s_data = ifc.tag_fifo_data_o; s_outstanding = ifc.outstanding_o;
        chk("rd_ready", 64'(s_rd_ready), 64'(ok && !pick_wr));
        chk("wr_ready", 64'(s_wr_ready), 64'(ok && pick_wr));
        chk("arvalid", 64'(ifc.arvalid_o), 64'(m_busy));
        chk("wren", 64'(s_wren), 64'(hs));
        chk("outstanding", 64'(s_outstanding), 64'(m_cnt));
        chk("arlen", 64'(ifc.arlen_o), 64'd7);
        if (m_busy) begin
            exp_araddr = ((m_addr / 64) % 1024) * 64;
            chk("araddr", 64'(s_araddr), 64'(exp_araddr));
            chk("arid", 64'(s_arid), 64'(m_id));
        end
        if (hs) chk("fifo_data", 64'(s_data), 64'({m_wr, m_id, m_addr}));
        // advance model
        if (hs && !done) m_cnt++;
        else if (done && !hs && m_cnt > 0) m_cnt--;
        if (ok) begin
            m_busy = 1; m_wr = pick_wr; m_last_wr = pick_wr;
            m_id = pick_wr ? wid : rid; m_addr = pick_wr ? wa : ra;
        end else if (hs) begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit arready, input bit done);
        step(0, '0, '0, 0, '0, '0, 0, arready, done);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        ifc.rd_req_valid_i = 1; ifc.rd_req_addr_i = 32'h1234; ifc.rd_req_id_i = 1;
        ifc.wr_req_valid_i = 1; ifc.wr_req_addr_i = 32'h5678; ifc.wr_req_id_i = 2;
        ifc.tag_fifo_afull_i = 0; ifc.arready_i = 1; ifc.done_i = 0;
        model_reset();
        #1;
        chk("rst_rd_ready", 64'(ifc.rd_req_ready_o), 64'd0);
        chk("rst_wr_ready", 64'(ifc.wr_req_ready_o), 64'd0);
        chk("rst_arvalid", 64'(ifc.arvalid_o), 64'd0);
        chk("rst_wren", 64'(ifc.tag_fifo_wren_o), 64'd0);
        chk("rst_data", 64'(ifc.tag_fifo_data_o), 64'd0);
        chk("rst_araddr", 64'(ifc.araddr_o), 64'd0);
        chk("rst_outstanding", 64'(ifc.outstanding_o), 64'd0);
        chk("arsize", 64'(ifc.arsize_o), 64'd3);
        chk("arburst", 64'(ifc.arburst_o), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Alternation with both requesters always valid: R,W,R,W
        for (int i = 0; i < 8; i++) begin
            step(1, 32'h0000_1000 + 32'(i * 64), 4'(i), 1, 32'h8000_0040 + 32'(i * 64), 4'(8 + i), 0, 1, 1);
            if (i % 2 == 0) begin
                chk("alt_rd_grant", 64'(s_rd_ready), 64'(i % 4 == 0));
                chk("alt_wr_grant", 64'(s_wr_ready), 64'(i % 4 == 2));
            end else begin
                chk("alt_desc_wr", 64'(s_data[AW+IW]), 64'(i % 4 == 3));
            end
        end

        // Single read with known address decomposition
        step(1, 32'h0001_2345, 4'd3, 0, '0, '0, 0, 1, 0);
        chk("single_rd_ready", 64'(s_rd_ready), 64'd1);
        idle(1, 0);
        chk("single_araddr", 64'(s_araddr), 64'h0000_2340);
        chk("single_arid", 64'(s_arid), 64'd3);
        chk("single_wren", 64'(s_wren), 64'd1);
        chk("single_data", 64'(s_data), 64'({1'b0, 4'd3, 32'h0001_2345}));
        idle(1, 0);
        chk("single_outstanding", 64'(s_outstanding), 64'd1);
        idle(1, 1);

        // Credit limit: four probes in flight block the fifth read
        for (int i = 0; i < 10; i++) step(1, 32'($urandom), 4'(i), 0, '0, '0, 0, 1, 0);
        chk("credit_blocked_ready", 64'(s_rd_ready), 64'd0);
        chk("credit_full", 64'(s_outstanding), 64'd4);
        step(1, 32'h0000_3000, 4'd5, 0, '0, '0, 0, 1, 1);
        step(1, 32'h0000_3000, 4'd5, 0, '0, '0, 0, 1, 0);
        chk("credit_regrant", 64'(s_rd_ready), 64'd1);
        idle(1, 0);
        idle(1, 0);
        chk("credit_back_to_max", 64'(s_outstanding), 64'd4);
        for (int i = 0; i < 5; i++) idle(1, 1);

        // AR stall: six cycles without arready, requests pending all along
        step(1, 32'hABCD_1FC0, 4'd9, 0, '0, '0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 32'h1111_1111, 4'd1, 1, 32'h2222_2222, 4'd2, 0, 0, 0);
        idle(1, 0);
        chk("stall_wren", 64'(s_wren), 64'd1);

        // Tag FIFO backpressure, then handshake coinciding with done
        for (int i = 0; i < 3; i++) step(1, 32'h0000_4000, 4'd4, 1, 32'h0000_5000, 4'd6, 1, 1, 0);
        chk("afull_no_grant", 64'(s_rd_ready | s_wr_ready), 64'd0);
        step(1, 32'h0000_4000, 4'd4, 1, 32'h0000_5000, 4'd6, 0, 1, 0);
        chk("afull_release_wr", 64'(s_wr_ready), 64'd1);
        idle(1, 1);
        idle(1, 0);
        chk("hs_done_same_cycle", 64'(s_outstanding), 64'd1);

        // Asynchronous reset while AR is pending
        step(1, 32'h0000_6000, 4'd7, 0, '0, '0, 0, 0, 0);
        idle(0, 0);
        ifc.rd_req_valid_i = 1; ifc.wr_req_valid_i = 1; ifc.arready_i = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_arvalid", 64'(ifc.arvalid_o), 64'd0);
        chk("arst_wren", 64'(ifc.tag_fifo_wren_o), 64'd0);
        chk("arst_ready", 64'(ifc.rd_req_ready_o | ifc.wr_req_ready_o), 64'd0);
        chk("arst_outstanding", 64'(ifc.outstanding_o), 64'd0);
        chk("arst_arid", 64'(ifc.arid_o), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 32'h0000_7000, 4'd1, 1, 32'h0000_8000, 4'd2, 0, 1, 0);
        chk("post_reset_tie_rd", 64'(s_rd_ready), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1), 32'($urandom), 4'($urandom), $urandom_range(0, 1),
                 32'($urandom), 4'($urandom), $urandom_range(0, 6) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dram_cache_req_arbiter.md
Name: dram_cache_req_arbiter

Overview:
- Front-end scheduler for the DRAM cache lookup path.
- Arbitrates host read and write requests onto the single DRAM AR channel, which issues one tag+data probe burst per request.
- Pushes the matching {write flag, ID, address} descriptor into the tag FIFO consumed by the tag comparator.
- Limits in-flight probes with a credit counter that the tag comparator replenishes.

Parameters:
- ADDR_WIDTH, 32, host/DRAM byte address width.
- ID_WIDTH, 4, AXI ID width.
- INDEX_WIDTH, 10, cache set index width.
- OFFSET_WIDTH, 6, line offset width.
- BURST_LEN, 8, beats per probe burst; arlen_o = BURST_LEN-1.
- MAX_OUTSTANDING, 4, maximum probes issued but not completed (1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_req_valid_i  in  1  host read request valid.
- rd_req_ready_o  out  1  read request accepted this cycle.
- rd_req_addr_i  in  ADDR_WIDTH  read address.
- rd_req_id_i  in  ID_WIDTH  read ID.
- wr_req_valid_i  in  1  host write request valid.
- wr_req_ready_o  out  1  write request accepted this cycle.
- wr_req_addr_i  in  ADDR_WIDTH  write address.
- wr_req_id_i  in  ID_WIDTH  write ID.
- arid_o  out  ID_WIDTH  DRAM AR ID.
- araddr_o  out  ADDR_WIDTH  DRAM probe address.
- arlen_o  out  8  burst length, constant BURST_LEN-1.
- arsize_o  out  3  constant log2 of the bus width in bytes.
- arburst_o  out  2  constant 2'b01 (INCR).
- arvalid_o  out  1  AR valid.
- arready_i  in  1  AR ready.
- tag_fifo_afull_i  in  1  tag FIFO almost full (at least one free slot while low).
- tag_fifo_wren_o  out  1  tag FIFO push strobe.
- tag_fifo_data_o  out  ADDR_WIDTH+ID_WIDTH+1  descriptor: [MSB]=1 for write, 0 for read; [ADDR_WIDTH+ID_WIDTH-1:ADDR_WIDTH]=ID; [ADDR_WIDTH-1:0]=full host address.
- done_i  in  1  one-cycle pulse from the tag comparator per completed probe.
- outstanding_o  out  4  current in-flight count.

Behaviour:
- Reset values: all ready, arvalid and wren outputs 0; arid/araddr/data 0; outstanding_o 0; state S_IDLE; last_grant=WRITE, so read wins the first tie.
- A reset assertion at any time clears everything immediately. An AR held mid-handshake is dropped. No FIFO push occurs for that AR.
- Grant condition, evaluated in S_IDLE only: (rd_req_valid_i | wr_req_valid_i) & !tag_fifo_afull_i & (outstanding < MAX_OUTSTANDING).
- Arbitration: if only one requester is valid, it is granted. If both are valid, the one not equal to last_grant is granted (round-robin). last_grant updates on each grant.
- Acceptance: ready of the granted side is high combinationally in the grant cycle T, and only when the grant condition holds. The other side's ready stays 0.
- Latching at T: ID, address, and write flag are registered. araddr = {ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH zeros, index bits, OFFSET_WIDTH zeros}, i.e. the set location; tag and offset bits are cleared. The FSM moves to S_ISSUE.
- S_ISSUE: arvalid_o=1 from T+1. arid_o, araddr_o and the descriptor are held stable until arready_i.
- On AR handshake (arvalid_o & arready_i) in cycle H:
  - tag_fifo_wren_o=1 in H with the latched descriptor.
  - The outstanding count increments.
  - The FSM returns to S_IDLE at H+1.
- Ready outputs are 0 throughout S_ISSUE. Peak throughput is one request per 2 cycles when arready is held high.
- Credit counter:
  - +1 on AR handshake; -1 on done_i.
  - Both in the same cycle: unchanged.
  - done_i at 0 is ignored (saturates at 0).
  - The count never exceeds MAX_OUTSTANDING.
- FIFO backpressure: afull is sampled only at grant. After a grant the push always proceeds, since one slot is guaranteed by the afull definition.
- Requests whose valid is dropped before grant are simply not served; no state is kept.

Test Plan:
- Single read: rd addr=0x0001_2345, id=3, arready held 1 -> rd_req_ready_o pulse at T; arvalid at T+1 with araddr=0x0000_2340 (INDEX=10, OFFSET=6), arid=3, arlen=7; wren at T+1 with data MSB=0, ID=3, addr=0x0001_2345; outstanding=1.
- Both valid continuously, arready=1, done_i pulses after each issue -> grants alternate R,W,R,W starting with R; one grant every 2 cycles; write descriptors carry MSB=1.
- Credit limit: 5 reads, no done_i -> 4 ARs issued, 5th ready stays 0; one done_i pulse -> 5th is granted the next idle cycle; outstanding returns to 4.
- AR stall: arready=0 for 6 cycles -> arvalid, araddr, arid stable; no wren until the handshake cycle; no readies during the stall.
- Backpressure and simultaneous events: tag_fifo_afull_i=1 with both requests valid -> no grant; deassert -> grant next cycle. Handshake and done_i in the same cycle -> outstanding unchanged.
- Reset in S_ISSUE with arvalid=1 -> all outputs 0 immediately (asynchronous), no wren; after release the first tie goes to read.
